// File: rtl/stage4_mem_wb_feed_pkg.sv
// Shared definitions for the MEM stage: bus widths, EX->MEM bus layout and load opcodes.
// EX and decode compile against the same widths and encodings.
package stage4_mem_wb_feed_pkg;

    localparam int WIDTH_ES_TO_MS_BUS = 74;
    localparam int WIDTH_MS_TO_WS_BUS = 70;
    localparam int WIDTH_MS_TO_DS_BUS = 39;

    localparam int ES_PC_LSB        = 0;
    localparam int ES_GR_WE_BIT     = 32;
    localparam int ES_RES_FROM_MEM  = 33;
    localparam int ES_DEST_LSB      = 34;
    localparam int ES_RESULT_LSB    = 39;
    localparam int ES_LD_OP_LSB     = 71;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b101,
        LD_HU = 3'b110
    } ld_op_e;

    // Field order matches the packed bit layout of es_to_ms_bus (MSB first).
    typedef struct packed {
        logic [2:0]  ld_op;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        res_from_mem;
        logic        gr_we;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/stage4_mem_wb_feed_mem_load_align.sv
// Combinational load extraction: selects the byte/halfword lane of a load word
// and sign- or zero-extends it; unknown opcodes return the whole word.
module mem_load_align
    import stage4_mem_wb_feed_pkg::*;
(
    input  logic [31:0] i_load_word,
    input  logic [2:0]  i_ld_op,
    input  logic [1:0]  i_addr,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_addr)
            2'b00:   w_byte = i_load_word[7:0];
            2'b01:   w_byte = i_load_word[15:8];
            2'b10:   w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase
    end

    // Halfword lane depends only on addr[1]; addr[0] is deliberately ignored.
    assign w_half = i_addr[1] ? i_load_word[31:16] : i_load_word[15:0];

    always_comb begin
        o_result = i_load_word;
        case (i_ld_op)
            LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_result = {24'd0, w_byte};
            LD_H:    o_result = {{16{w_half[15]}}, w_half};
            LD_HU:   o_result = {16'd0, w_half};
            default: o_result = i_load_word;
        endcase
    end

endmodule

// File: rtl/stage4_mem_wb_feed.sv
// MEM pipeline stage: registers the EX bus, holds SRAM read data across write-back
// stalls, extracts load data and drives the write-back and decode-forwarding buses.
module stage4_mem_wb_feed
    import stage4_mem_wb_feed_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          es_to_ms_valid,
    output logic                          ms_allow_in,
    input  logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
    input  logic [31:0]                   data_sram_rdata,
    input  logic                          ws_allow_in,
    output logic                          ms_to_ws_valid,
    output logic [WIDTH_MS_TO_WS_BUS-1:0] ms_to_ws_bus,
    output logic [WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus
);

    logic        r_ms_valid;
    es_to_ms_t   r_bus;
    logic        r_hold_vld;
    logic [31:0] r_hold_data;

    logic        w_ready_go;
    logic        w_leave;
    logic        w_enter;
    logic [31:0] w_load_word;
    logic [31:0] w_extracted;
    logic [31:0] w_final_result;

    assign w_ready_go     = 1'b1;
    assign ms_allow_in    = !r_ms_valid || (w_ready_go && ws_allow_in);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign w_leave        = r_ms_valid && ws_allow_in;
    assign w_enter        = es_to_ms_valid && ms_allow_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allow_in) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bus <= '0;
        end else if (w_enter) begin
            r_bus <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    // The SRAM only presents this instruction's data on its first MEM cycle;
    // EX moves on to a new address afterwards, so a stall must capture it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (w_leave || w_enter) begin
            r_hold_vld  <= 1'b0;
        end else if (r_ms_valid && !ws_allow_in && !r_hold_vld) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= data_sram_rdata;
        end
    end

    assign w_load_word = r_hold_vld ? r_hold_data : data_sram_rdata;

    mem_load_align u_load_align (
        .i_load_word (w_load_word),
        .i_ld_op     (r_bus.ld_op),
        .i_addr      (r_bus.result[1:0]),
        .o_result    (w_extracted)
    );

    assign w_final_result = r_bus.res_from_mem ? w_extracted : r_bus.result;

    assign ms_to_ws_bus = {w_final_result, r_bus.dest, r_bus.gr_we, r_bus.pc};
    assign ms_to_ds_bus = {r_ms_valid && r_bus.gr_we, r_bus.dest, r_bus.res_from_mem, w_final_result};

endmodule

// File: tb/tb_stage4_mem_wb_feed.sv
// Testbench for stage4_mem_wb_feed: directed scenarios followed by random traffic,
// each cycle compared against a per-instruction reference model.
module tb_stage4_mem_wb_feed;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allow_in;
    logic [73:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ws_allow_in;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] ms_to_ds_bus;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the instruction currently in MEM and the word it loaded.
    logic        m_valid = 1'b0;
    logic [73:0] m_bus   = '0;
    logic        m_first = 1'b0;
    logic [31:0] m_word  = '0;

    always #5 clk = ~clk;

    stage4_mem_wb_feed dut (
        .clk             (clk),
        .reset           (reset),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allow_in     (ms_allow_in),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ws_allow_in     (ws_allow_in),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_ds_bus    (ms_to_ds_bus)
    );

    function automatic logic [73:0] mk(input logic [2:0] op, input logic [31:0] res,
                                       input logic [4:0] dest, input logic rfm,
                                       input logic we, input logic [31:0] pc);
        return {op, res, dest, rfm, we, pc};
    endfunction

    function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'b001:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'b101:  return b;
            3'b010:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'b110:  return h;
            default: return w;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    // mode: 0 none, 1 final_result constant, 2 whole ds bus constant, 3 fwd_we constant.
    task automatic cyc(input logic ev, input logic [73:0] bus, input logic wa,
                       input logic [31:0] rd, input int mode, input logic [38:0] k,
                       input string tag);
        logic [31:0] word;
        logic [31:0] fin;
        logic        rfm;
        es_to_ms_valid  = ev;
        es_to_ms_bus    = bus;
        ws_allow_in     = wa;
        data_sram_rdata = rd;
        #2;
        chk("allow_in", {69'd0, ms_allow_in}, {69'd0, (!m_valid || wa)});
        chk("ws_valid", {69'd0, ms_to_ws_valid}, {69'd0, m_valid});
        if (m_valid) begin
            word = m_first ? rd : m_word;
            if (m_first) m_word = rd;
            rfm  = m_bus[33];
            fin  = rfm ? ref_ext(m_bus[73:71], m_bus[40:39], word) : m_bus[70:39];
            chk("ws_bus", ms_to_ws_bus, {fin, m_bus[38:34], m_bus[32], m_bus[31:0]});
            chk("ds_bus", {31'd0, ms_to_ds_bus}, {31'd0, m_bus[32], m_bus[38:34], rfm, fin});
        end else begin
            chk("fwd_we_idle", {69'd0, ms_to_ds_bus[38]}, 70'd0);
        end
        if (mode == 1) chk(tag, {38'd0, ms_to_ws_bus[69:38]}, {38'd0, k[31:0]});
        if (mode == 2) chk(tag, {31'd0, ms_to_ds_bus}, {31'd0, k});
        if (mode == 3) chk(tag, {69'd0, ms_to_ds_bus[38]}, {69'd0, k[0]});
        @(posedge clk);
        #1;
        if (!m_valid || wa) begin
            m_valid = ev;
            if (ev) begin
                m_bus   = bus;
                m_first = 1'b1;
            end
        end else begin
            m_first = 1'b0;
        end
    endtask

    initial begin
        reset           = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        ws_allow_in     = 1'b0;
        data_sram_rdata = '0;
        #12;
        chk("rst_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("rst_allow_in", {69'd0, ms_allow_in}, 70'd1);
        chk("rst_ws_bus", ms_to_ws_bus, 70'd0);
        chk("rst_ds_ctrl", {63'd0, ms_to_ds_bus[38:32]}, 70'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // LD_W basic
        cyc(1'b1, mk(3'b000, 32'h1000, 5'd3, 1'b1, 1'b1, 32'h0000_0100), 1'b1, 32'h0, 0, '0, "");
        cyc(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1, 39'hDEAD_BEEF, "t1_ldw");
        cyc(1'b0, '0, 1'b1, 32'h0BAD_F00D, 0, '0, "");

        // Sub-word loads, back to back
        cyc(1'b1, mk(3'b001, 32'h1003, 5'd4, 1'b1, 1'b1, 32'h104), 1'b1, 32'h0, 0, '0, "");
        cyc(1'b1, mk(3'b101, 32'h1003, 5'd4, 1'b1, 1'b1, 32'h108), 1'b1, 32'h80FF_1234, 1, 39'hFFFF_FF80, "t2_ldb");
        cyc(1'b1, mk(3'b010, 32'h1002, 5'd4, 1'b1, 1'b1, 32'h10C), 1'b1, 32'h80FF_1234, 1, 39'h0000_0080, "t2_ldbu");
        cyc(1'b1, mk(3'b110, 32'h1002, 5'd4, 1'b1, 1'b1, 32'h110), 1'b1, 32'h80FF_1234, 1, 39'hFFFF_80FF, "t2_ldh");
        cyc(1'b0, '0, 1'b1, 32'h80FF_1234, 1, 39'h0000_80FF, "t2_ldhu");

        // Stall holds first-cycle data; leave+enter same cycle uses raw data
        cyc(1'b1, mk(3'b000, 32'h2000, 5'd6, 1'b1, 1'b1, 32'h200), 1'b1, 32'h0, 0, '0, "");
        cyc(1'b1, mk(3'b000, 32'h2004, 5'd7, 1'b1, 1'b1, 32'h204), 1'b0, 32'h1111_1111, 0, '0, "");
        cyc(1'b1, mk(3'b000, 32'h2004, 5'd7, 1'b1, 1'b1, 32'h204), 1'b0, 32'h2222_2222, 0, '0, "");
        cyc(1'b1, mk(3'b000, 32'h2004, 5'd7, 1'b1, 1'b1, 32'h204), 1'b0, 32'h2222_2222, 0, '0, "");
        cyc(1'b1, mk(3'b000, 32'h2004, 5'd7, 1'b1, 1'b1, 32'h204), 1'b1, 32'h2222_2222, 1, 39'h1111_1111, "t3_held");
        cyc(1'b0, '0, 1'b1, 32'h3333_3333, 1, 39'h3333_3333, "t4_new");

        // Non-memory forwarding
        cyc(1'b1, mk(3'b000, 32'h42, 5'd5, 1'b0, 1'b1, 32'h300), 1'b1, 32'h0, 0, '0, "");
        cyc(1'b0, '0, 1'b1, 32'hCAFE_0000, 2, {1'b1, 5'd5, 1'b0, 32'h42}, "t5_ds");
        cyc(1'b0, '0, 1'b1, 32'hCAFE_0001, 3, 39'd0, "t5_fwd_idle");

        // Asynchronous reset in the middle of a stall
        cyc(1'b1, mk(3'b000, 32'h3000, 5'd8, 1'b1, 1'b1, 32'h400), 1'b1, 32'h0, 0, '0, "");
        cyc(1'b0, '0, 1'b0, 32'h4444_4444, 0, '0, "");
        es_to_ms_valid = 1'b0;
        ws_allow_in    = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("t6_rst_allow", {69'd0, ms_allow_in}, 70'd1);
        chk("t6_rst_bus", ms_to_ws_bus, 70'd0);
        m_valid = 1'b0;
        m_first = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b1, mk(3'b000, 32'h3004, 5'd9, 1'b1, 1'b1, 32'h404), 1'b1, 32'h0, 0, '0, "");
        cyc(1'b0, '0, 1'b1, 32'h5555_5555, 1, 39'h5555_5555, "t6_after_rst");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 7),
                mk(3'($urandom_range(0, 7)), $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom),
                ($urandom_range(0, 9) < 6), $urandom, 0, '0, "");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
